// File: rtl/packet_ram_bytewise.sv
// Packet buffer RAM: word-wide writes from the snooper, byte-granular 1/2/4-byte reads
// for the load unit, byte-exact length tracking. Define PKTRAM_BOUNDS_CHECK_EN for read bounds checking.
module packet_ram_bytewise #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 32
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        wr_en,
  input  logic [ADDR_WIDTH-1:0]                       wr_addr,
  input  logic [DATA_WIDTH-1:0]                       wr_data,
  input  logic                                        wr_last,
  input  logic [$clog2(DATA_WIDTH/8):0]               wr_last_bytes,
  input  logic                                        len_rst,
  output logic [LEN_WIDTH-1:0]                        len,
  input  logic                                        rd_en,
  output logic                                        rd_ready,
  input  logic [ADDR_WIDTH+$clog2(DATA_WIDTH/8)-1:0]  rd_addr,
  input  logic [1:0]                                  rd_size,
  output logic                                        rd_valid,
  output logic [31:0]                                 rd_data,
  output logic                                        rd_oob
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int BA_W  = ADDR_WIDTH + OFF_W;

  // Read handshake: a request is taken when rd_en && rd_ready. rd_ready is low for any
  // cycle with wr_en (the write owns port A); a refused request is dropped, never queued,
  // and produces no rd_valid, so the requester must retry.
  logic accept;
  assign rd_ready = ~wr_en;
  assign accept   = rd_en & ~wr_en;

  // ---------------- storage ----------------
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] word_a;
  logic [DATA_WIDTH-1:0] word_b;
  logic [ADDR_WIDTH-1:0] rd_word;
  logic [ADDR_WIDTH-1:0] rd_word_nxt;

  assign rd_word     = rd_addr[BA_W-1:OFF_W];
  assign rd_word_nxt = rd_word + ADDR_WIDTH'(1);  // wraps DEPTH-1 -> 0

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end else if (rd_en) begin
      word_a <= mem[rd_word];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      word_b <= mem[rd_word_nxt];
    end
  end

  // ---------------- stage 1: request side-band ----------------
  logic             v1;
  logic [OFF_W-1:0] off1;
  logic [1:0]       size1;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
    end else begin
      v1 <= accept;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      off1  <= rd_addr[OFF_W-1:0];
      size1 <= rd_size;
    end
  end

`ifdef PKTRAM_BOUNDS_CHECK_EN
  localparam int CMP_W = LEN_WIDTH + 1;
  logic [2:0] size_bytes;
  logic       oob_now;
  logic       oob1;

  always_comb begin
    size_bytes = 3'd4;
    case (rd_size)
      2'b00:   size_bytes = 3'd1;
      2'b01:   size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
    oob_now = (CMP_W'(rd_addr) + CMP_W'(size_bytes)) > {1'b0, len};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      oob1 <= 1'b0;
    end else if (accept) begin
      oob1 <= oob_now;
    end
  end
`endif

  // ---------------- byte extraction ----------------
  logic [2*DATA_WIDTH-1:0] cat_shift;
  logic [31:0]             win;
  logic [31:0]             extracted;

  always_comb begin
    cat_shift = {word_a, word_b} << {off1, 3'b000};
    // BYTES >= 4, so off+3 always stays inside the two-word window.
    win       = cat_shift[2*DATA_WIDTH-1 -: 32];
    extracted = win;
    case (size1)
      2'b00:   extracted = {24'd0, win[31:24]};
      2'b01:   extracted = {16'd0, win[31:16]};
      default: extracted = win;
    endcase
  end

  // ---------------- stage 2: result ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= 32'd0;
    end else begin
      rd_valid <= v1;
      if (v1) begin
`ifdef PKTRAM_BOUNDS_CHECK_EN
        rd_data <= oob1 ? 32'd0 : extracted;
`else
        rd_data <= extracted;
`endif
      end
    end
  end

`ifdef PKTRAM_BOUNDS_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_oob <= 1'b0;
    end else if (v1) begin
      rd_oob <= oob1;
    end
  end
`else
  assign rd_oob = 1'b0;
`endif

  // ---------------- length tracking ----------------
  logic [LEN_WIDTH-1:0] eff_last;
  logic [LEN_WIDTH-1:0] cand;
  logic [LEN_WIDTH-1:0] len_base;

  always_comb begin
    eff_last = (wr_last_bytes == '0) ? LEN_WIDTH'(BYTES) : LEN_WIDTH'(wr_last_bytes);
    cand     = (LEN_WIDTH'(wr_addr) << OFF_W) + (wr_last ? eff_last : LEN_WIDTH'(BYTES));
    // A same-cycle len_rst clears first, so the write alone sets the new length.
    len_base = len_rst ? '0 : len;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len <= '0;
    end else if (wr_en) begin
      len <= (cand > len_base) ? cand : len_base;
    end else if (len_rst) begin
      len <= '0;
    end
  end

endmodule

// File: tb/tb_packet_ram_bytewise.sv
// Bench for packet_ram_bytewise (ADDR_WIDTH=4, DATA_WIDTH=32): directed plan steps, then
// random traffic checked against a byte-array model of the packet buffer.
module tb_packet_ram_bytewise;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int LW = 32;
  localparam int NBYTES = 64;

`ifdef PKTRAM_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_last;
  logic [2:0]    wr_last_bytes;
  logic          len_rst;
  logic [LW-1:0] len;
  logic          rd_en;
  logic          rd_ready;
  logic [AW+1:0] rd_addr;
  logic [1:0]    rd_size;
  logic          rd_valid;
  logic [31:0]   rd_data;
  logic          rd_oob;

  packet_ram_bytewise #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_last(wr_last), .wr_last_bytes(wr_last_bytes), .len_rst(len_rst), .len(len),
    .rd_en(rd_en), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_size(rd_size),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_oob(rd_oob)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard / model ----------------
  int          checks = 0;
  int          fails  = 0;
  bit          mon_en = 1'b0;
  logic [32:0] exp_q[$];   // {oob, data}
  int          due_q[$];   // cycle in which the result must appear
  logic [7:0]  mem_b[NBYTES];
  logic [LW-1:0] len_m;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [32:0] model_read(input int a, input int s);
    int n;
    logic [31:0] v;
    logic o;
    n = (s == 0) ? 1 : (s == 1) ? 2 : 4;
    v = 32'd0;
    for (int i = 0; i < n; i++) v = (v << 8) | {24'd0, mem_b[(a + i) % NBYTES]};
    o = BC && ((longint'(a) + n) > longint'(len_m));
    if (o) v = 32'd0;
    return {o, v};
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        check("rd_valid", {63'd0, rd_valid}, 64'd1);
        check("rd_data", {32'd0, rd_data}, {32'd0, exp_q[0][31:0]});
        check("rd_oob", {63'd0, rd_oob}, {63'd0, exp_q[0][32]});
        void'(due_q.pop_front());
        void'(exp_q.pop_front());
      end else begin
        check("rd_valid_idle", {63'd0, rd_valid}, 64'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One clock cycle of stimulus; updates the model and checks rd_ready and len.
  task automatic cycle_op(input bit we, input int wa, input logic [31:0] wd, input bit wl,
                          input int wlb, input bit lr, input bit re, input int ra, input int rs,
                          input bit use_model, input logic [32:0] exp_v, input bit expect_out);
    longint c;
    wr_en = we; wr_addr = wa[AW-1:0]; wr_data = wd; wr_last = wl;
    wr_last_bytes = wlb[2:0]; len_rst = lr;
    rd_en = re; rd_addr = ra[AW+1:0]; rd_size = rs[1:0];
    #1;
    check("rd_ready", {63'd0, rd_ready}, {63'd0, !we});
    if (re && !we && expect_out) begin
      exp_q.push_back(use_model ? model_read(ra, rs) : exp_v);
      due_q.push_back(cyc + 2);
    end
    if (we) begin
      c = longint'(wa) * 4 + (wl ? ((wlb == 0) ? 4 : wlb) : 4);
      for (int i = 0; i < 4; i++) mem_b[wa * 4 + i] = wd[31 - 8 * i -: 8];
      if (lr || (c > longint'(len_m))) len_m = LW'(c);
    end else if (lr) begin
      len_m = '0;
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; len_rst = 1'b0;
    check("len", {32'd0, len}, {32'd0, len_m});
  endtask

  task automatic wr(input int a, input logic [31:0] d, input bit l, input int lb);
    cycle_op(1, a, d, l, lb, 0, 0, 0, 0, 0, 33'd0, 0);
  endtask

  task automatic rd(input int a, input int s, input logic [32:0] e);
    cycle_op(0, 0, 32'd0, 0, 0, 0, 1, a, s, 0, e, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle_op(0, 0, 32'd0, 0, 0, 0, 0, 0, 0, 0, 33'd0, 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_last = 1'b0;
    wr_last_bytes = '0; len_rst = 1'b0; rd_en = 1'b0; rd_addr = '0; rd_size = '0;
    len_m = '0;
    for (int i = 0; i < NBYTES; i++) mem_b[i] = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    check("reset_len", {32'd0, len}, 64'd0);
    check("reset_rd_valid", {63'd0, rd_valid}, 64'd0);
    check("reset_rd_data", {32'd0, rd_data}, 64'd0);
    check("reset_rd_oob", {63'd0, rd_oob}, 64'd0);

    // Length tracking
    wr(0, 32'h11223344, 0, 0);
    wr(1, 32'h55667788, 0, 0);
    wr(2, 32'h99AABBCC, 0, 0);
    check("len_12", {32'd0, len}, 64'd12);
    cycle_op(0, 0, 32'd0, 0, 0, 1, 0, 0, 0, 0, 33'd0, 0);
    check("len_cleared", {32'd0, len}, 64'd0);
    wr(0, 32'h11223344, 0, 0);
    wr(1, 32'h55667788, 1, 3);
    check("len_7", {32'd0, len}, 64'd7);

    // Unaligned and back-to-back reads
    rd(2, 2, {1'b0, 32'h33445566});
    idle(3);
    rd(5, 0, {1'b0, 32'h00000066});
    rd(3, 1, {1'b0, 32'h00004455});
    rd(0, 2, {1'b0, 32'h11223344});
    idle(3);
    rd(5, 2, BC ? {1'b1, 32'h0} : {1'b0, 32'h66778899});
    idle(3);

    // Wrap from the last word into word 0
    wr(15, 32'hDEADBEEF, 0, 0);
    rd(62, 2, BC ? {1'b1, 32'h0} : {1'b0, 32'hBEEF1122});
    idle(3);

    // Write/read conflict: request dropped
    cycle_op(1, 3, 32'hCAFEF00D, 0, 0, 0, 1, 0, 2, 0, 33'd0, 0);
    idle(3);

    // Reset in N+1 of an accepted read
    cycle_op(0, 0, 32'd0, 0, 0, 0, 1, 0, 2, 0, 33'd0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    len_m = '0;
    check("len_after_rst", {32'd0, len}, 64'd0);
    idle(3);

    // len_rst together with a write
    wr(5, 32'h01020304, 0, 0);
    check("len_24", {32'd0, len}, 64'd24);
    cycle_op(1, 3, 32'hA1B2C3D4, 0, 0, 1, 0, 0, 0, 0, 33'd0, 0);
    check("len_16", {32'd0, len}, 64'd16);

    // Random traffic against the byte-array model
    for (int w = 0; w < 16; w++) wr(w, $urandom, 0, 0);
    for (int k = 0; k < 400; k++) begin
      int op;
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2, 3: cycle_op(0, 0, 32'd0, 0, 0, 0, 1, $urandom_range(0, 63), $urandom_range(0, 3), 1, 33'd0, 1);
        4, 5:       cycle_op(1, $urandom_range(0, 15), $urandom, $urandom_range(0, 1), $urandom_range(0, 4), 0, 0, 0, 0, 1, 33'd0, 1);
        6:          cycle_op(1, $urandom_range(0, 15), $urandom, $urandom_range(0, 1), $urandom_range(0, 4), 0, 1, $urandom_range(0, 63), $urandom_range(0, 3), 1, 33'd0, 1);
        7:          cycle_op(0, 0, 32'd0, 0, 0, 1, 0, 0, 0, 1, 33'd0, 1);
        8:          cycle_op(1, $urandom_range(0, 15), $urandom, $urandom_range(0, 1), $urandom_range(0, 4), 1, 0, 0, 0, 1, 33'd0, 1);
        default:    idle(1);
      endcase
    end

    idle(4);
    check("drain", 64'(exp_q.size()), 64'd0);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/packet_ram_bytewise.md
Name: packet_ram_bytewise

Overview:
- Next-generation packet buffer RAM for the BPF VM packet memory.
- Generalises the fixed 32-bit dual-read packet RAM to a parametrised word width.
- Adds byte-granular, size-selectable unaligned reads (1/2/4 bytes) with a pipelined extract stage, and byte-exact packet length tracking.
- Sits between the packet snooper (write side) and the CPU load unit (read side).

Parameters:
ADDR_WIDTH, 10, word-address width; depth = 2**ADDR_WIDTH words
DATA_WIDTH, 32, word width in bits; power of two, >= 32; BYTES = DATA_WIDTH/8
LEN_WIDTH, 32, width of byte-length output

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
wr_en  in  1  write strobe
wr_addr  in  ADDR_WIDTH  word address
wr_data  in  DATA_WIDTH  word data; byte 0 in MSBs (network order)
wr_last  in  1  this word ends the packet
wr_last_bytes  in  $clog2(BYTES)+1  valid bytes in last word, 1..BYTES; 0 means BYTES
len_rst  in  1  clear length (reject/forward done)
len  out  LEN_WIDTH  packet length in bytes
rd_en  in  1  read request
rd_ready  out  1  read request accepted this cycle
rd_addr  in  ADDR_WIDTH+$clog2(BYTES)  byte address
rd_size  in  2  00 = 1B, 01 = 2B, 10 = 4B, 11 = treated as 4B
rd_valid  out  1  rd_data valid
rd_data  out  32  result, right-justified, zero-extended
rd_oob  out  1  read exceeded len (feature-dependent)

Behaviour:
- Reset: len = 0, rd_valid = 0, rd_data = 0, rd_oob = 0, pipeline emptied. RAM contents are not reset.
- Storage: inferred BRAM, DEPTH x DATA_WIDTH.
  - Port A: write port, also reads word W = rd_addr >> log2(BYTES).
  - Port B: reads word W+1 (mod DEPTH).
  - Must infer block RAM with no output-register reset.
- rd_ready = ~wr_en (combinational).
  - Write has priority.
  - rd_en with wr_en high is dropped: no rd_valid is produced. The requester retries.
- Read pipeline, request accepted in cycle N:
  - N+1: both words registered from RAM; byte offset, size and OOB check registered alongside.
  - N+2: rd_data = bytes [off .. off+size-1] of the 2*DATA_WIDTH concatenation {word W, word W+1}, first byte in the most significant position. rd_valid = 1 for exactly one cycle.
  - Fully pipelined: one accepted request per cycle gives one rd_valid per cycle, in order.
- Wrap: W = DEPTH-1 reads word 0 as the second word. No error.
- Length, on wr_en:
  - cand = wr_addr*BYTES + (wr_last ? eff_last_bytes : BYTES), where eff_last_bytes is wr_last_bytes with 0 mapped to BYTES.
  - len <= max(len, cand).
  - Arithmetic is at LEN_WIDTH width.
- len_rst without wr_en: len <= 0.
- len_rst with wr_en in the same cycle: len <= cand (clear, then apply the write).
- rst mid-pipeline: in-flight reads are discarded; rd_valid is 0 in the cycle after rst.
- Read-during-write to the same word: not possible, because reads are blocked while wr_en is high.

Optional Feature:
- Macro: PKTRAM_BOUNDS_CHECK_EN.
- Defined:
  - At acceptance, oob = (rd_addr + size_bytes > len), computed at LEN_WIDTH+1 bits.
  - This is pipelined; at N+2, rd_oob = oob and rd_data is forced to 0 when oob = 1.
- Undefined:
  - rd_oob is tied 0.
  - rd_data is the raw extracted bytes.
  - No comparator is synthesised.

Test Plan (DATA_WIDTH=32, ADDR_WIDTH=4):
1. Write words 0..2 = 0x11223344, 0x55667788, 0x99AABBCC with no wr_last -> len = 12. Pulse len_rst -> len = 0. Rewrite word 0 and word 1, with wr_last=1 and wr_last_bytes=3 on word 1 -> len = 7.
2. rd_en, addr=2, size=10 in cycle N -> rd_valid and rd_data = 0x33445566 in N+2 only; rd_oob = 0.
3. Back-to-back reads in three consecutive cycles: (5, 1B), (3, 2B), (0, 4B) -> three consecutive rd_valid cycles with 0x00000066, 0x00004455, 0x11223344.
4. Read addr=5, size=4B with len=7:
   - Macro defined -> rd_oob = 1, rd_data = 0.
   - Macro undefined -> rd_oob = 0, rd_data = 0x66778899.
5. Wrap: write word 15 = 0xDEADBEEF, then read addr=62, size 4B -> 0xBEEF1122.
6. Conflict and reset:
   - wr_en and rd_en in the same cycle -> rd_ready = 0 and no rd_valid at N+2.
   - rst asserted in N+1 of an accepted read -> rd_valid = 0 at N+2, len = 0.
   - len_rst together with a wr_en to word 3 (wr_last=0) -> len = 16.
